// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-side stage (MAR/MDR + big-endian byte RAM).
// Optional MEM_ALIGN_CHECK_EN flags misaligned word accesses.
module mem_access_ctrl #(
    parameter int    DEPTH_BYTES = 1024,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        marLoad,
    input  logic        mdrLoad,
    input  logic        memEnable,
    input  logic        RW,
    input  logic [1:0]  size,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    output logic [31:0] mar_out,
    output logic [31:0] mdr_out,
    output logic        MOC,
    output logic        busy,
    output logic        align_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_mar;
    logic [31:0] r_mdr;
    logic        r_rw;
    logic [1:0]  r_size;
    logic        r_moc;
    logic        r_busy;
    logic [7:0]  r_mem [DEPTH_BYTES];

    logic          w_word;
    logic          w_misalign;
    logic [AW-1:0] w_a0;
    logic [AW-1:0] w_a1;
    logic [AW-1:0] w_a2;
    logic [AW-1:0] w_a3;
    logic [31:0]   w_rdata;
    logic          w_we;

    // size 11 behaves as a word access
    assign w_word = (r_size == 2'b00) || (r_size == 2'b11);

`ifdef MEM_ALIGN_CHECK_EN
    logic r_align;
    assign w_misalign = w_word && (r_mar[1:0] != 2'b00);
    assign w_a0       = r_mar[AW-1:0];
    assign align_err  = r_align;
`else
    assign w_misalign = 1'b0;
    assign w_a0       = w_word ? {r_mar[AW-1:2], 2'b00}
                               : r_mar[AW-1:0];
    assign align_err  = 1'b0;
`endif

    // byte indices wrap naturally in AW bits
    assign w_a1 = w_a0 + AW'(1);
    assign w_a2 = w_a0 + AW'(2);
    assign w_a3 = w_a0 + AW'(3);

    // write only in a live XFER cycle; reset forces IDLE so no write
    assign w_we = reset && (r_state == S_XFER) && memEnable
                  && !r_rw && !w_misalign;

    assign mar_out = r_mar;
    assign mdr_out = r_mdr;
    assign MOC     = r_moc;
    assign busy    = r_busy;

    // combinational RAM read with big-endian packing and extension
    always_comb begin
        w_rdata = {r_mem[w_a0], r_mem[w_a1],
                   r_mem[w_a2], r_mem[w_a3]};
        if (r_size == 2'b01) begin
            w_rdata = {{24{r_mem[w_a0][7]}}, r_mem[w_a0]};
        end else if (r_size == 2'b10) begin
            w_rdata = {24'h0, r_mem[w_a0]};
        end
    end

    // RAM write port, MSB of MDR goes to the lowest address
    always_ff @(posedge clk) begin
        if (w_we) begin
            if (w_word) begin
                r_mem[w_a0] <= r_mdr[31:24];
                r_mem[w_a1] <= r_mdr[23:16];
                r_mem[w_a2] <= r_mdr[15:8];
                r_mem[w_a3] <= r_mdr[7:0];
            end else begin
                r_mem[w_a0] <= r_mdr[7:0];
            end
        end
    end

    // control FSM with registered MOC/busy and MAR/MDR ownership
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_mar   <= 32'h0;
            r_mdr   <= 32'h0;
            r_rw    <= 1'b0;
            r_size  <= 2'b00;
            r_moc   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_align <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (marLoad) r_mar <= addr_in;
                    if (mdrLoad) r_mdr <= data_in;
                    if (memEnable) begin
                        r_rw   <= RW;
                        r_size <= size;
                        r_busy <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                        r_align <= 1'b0;
`endif
                        if (LP_WAIT == 4'd0) begin
                            r_state <= S_XFER;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LP_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!memEnable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= S_XFER;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_XFER: begin
                    if (!memEnable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_DONE;
                        r_moc   <= 1'b1;
                        if (w_misalign) begin
`ifdef MEM_ALIGN_CHECK_EN
                            r_align <= 1'b1;
`endif
                        end else if (r_rw) begin
                            r_mdr <= w_rdata;
                        end
                    end
                end
                S_DONE: begin
                    if (!memEnable) begin
                        r_state <= S_IDLE;
                        r_moc   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: vector table, corner sequences and random
// traffic checked against a byte-array model of the RAM.
module tb_mem_access_ctrl;

    localparam int DEPTH = 1024;
    localparam int WC    = 2;

    logic        clk;
    logic        reset;
    logic        marLoad;
    logic        mdrLoad;
    logic        memEnable;
    logic        RW;
    logic [1:0]  size;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [31:0] mar_out;
    logic [31:0] mdr_out;
    logic        MOC;
    logic        busy;
    logic        align_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] model [DEPTH];

    typedef struct {
        logic        rw;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    mem_access_ctrl #(
        .DEPTH_BYTES(DEPTH),
        .WAIT_CYCLES(WC),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .reset(reset),
        .marLoad(marLoad),
        .mdrLoad(mdrLoad),
        .memEnable(memEnable),
        .RW(RW),
        .size(size),
        .addr_in(addr_in),
        .data_in(data_in),
        .mar_out(mar_out),
        .mdr_out(mdr_out),
        .MOC(MOC),
        .busy(busy),
        .align_err(align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // word address used by the model for a word access
    function automatic int m_word_base(input logic [31:0] addr);
        int a;
        a = int'(addr % DEPTH);
`ifndef MEM_ALIGN_CHECK_EN
        a = a - (a % 4);
`endif
        return a;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] sz,
                                           input logic [31:0] addr);
        logic [31:0] v;
        int a;
        logic [7:0] b;
        b = model[int'(addr % DEPTH)];
        if (sz == 2'b01) return 32'($signed(b));
        if (sz == 2'b10) return {24'h0, b};
        a = m_word_base(addr);
        v = 0;
        for (int i = 0; i < 4; i++)
            v = (v << 8) | 32'(model[(a + i) % DEPTH]);
        return v;
    endfunction

    task automatic m_write(input logic [1:0] sz,
                           input logic [31:0] addr,
                           input logic [31:0] d);
        int a;
        if (sz == 2'b01 || sz == 2'b10) begin
            model[int'(addr % DEPTH)] = d[7:0];
        end else begin
            a = m_word_base(addr);
            for (int i = 0; i < 4; i++)
                model[(a + i) % DEPTH] = 8'(d >> (24 - 8 * i));
        end
    endtask

    // full handshake: load MAR/MDR, request, wait MOC, release
    task automatic access(input logic rw,
                          input logic [1:0] sz,
                          input logic [31:0] addr,
                          input logic [31:0] data,
                          output logic [31:0] res);
        int n;
        @(negedge clk);
        addr_in   = addr;
        data_in   = data;
        marLoad   = 1'b1;
        mdrLoad   = 1'b1;
        memEnable = 1'b1;
        RW        = rw;
        size      = sz;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            marLoad = 1'b0;
            mdrLoad = 1'b0;
            n++;
        end while (!MOC && n < 40);
        chk("latency", n, WC + 2);
        res = mdr_out;
        memEnable = 1'b0;
        @(posedge clk);
        #1;
        chk("moc_release", {31'h0, MOC}, 0);
        chk("busy_release", {31'h0, busy}, 0);
    endtask

    logic [31:0] res;
    logic [31:0] e;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        rw;
    logic        seen;
    int          n;

    initial begin
        reset     = 1'b0;
        marLoad   = 1'b0;
        mdrLoad   = 1'b0;
        memEnable = 1'b0;
        RW        = 1'b0;
        size      = 2'b00;
        addr_in   = 32'h0;
        data_in   = 32'h0;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h0;

        tbl[0]  = '{1'b0, 2'b00, 32'h010, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 2'b00, 32'h010, 32'h0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 2'b01, 32'h011, 32'h0, 32'hFFFFFFAD};
        tbl[3]  = '{1'b1, 2'b10, 32'h011, 32'h0, 32'h000000AD};
        tbl[4]  = '{1'b0, 2'b10, 32'h400, 32'h5A, 32'h0000005A};
        tbl[5]  = '{1'b1, 2'b10, 32'h000, 32'h0, 32'h0000005A};
        tbl[6]  = '{1'b0, 2'b00, 32'h7FC, 32'h11223344, 32'h11223344};
        tbl[7]  = '{1'b1, 2'b00, 32'h3FC, 32'h0, 32'h11223344};
        tbl[8]  = '{1'b1, 2'b01, 32'h3FF, 32'h0, 32'h00000044};
        tbl[9]  = '{1'b1, 2'b11, 32'h010, 32'h0, 32'hDEADBEEF};
        tbl[10] = '{1'b1, 2'b01, 32'h012, 32'h0, 32'hFFFFFFBE};
        tbl[11] = '{1'b0, 2'b01, 32'h013, 32'hFFFFFF01, 32'hFFFFFF01};
        tbl[12] = '{1'b1, 2'b00, 32'h010, 32'h0, 32'hDEADBE01};

        // reset values
        #2;
        chk("rst_mar", mar_out, 0);
        chk("rst_mdr", mdr_out, 0);
        chk("rst_moc", {31'h0, MOC}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_align", {31'h0, align_err}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // directed vectors
        for (int i = 0; i < 13; i++) begin
            access(tbl[i].rw, tbl[i].sz, tbl[i].addr,
                   tbl[i].data, res);
            chk($sformatf("vec%0d", i), res, tbl[i].exp);
        end

        // loads ignored while busy, MOC held in DONE
        @(negedge clk);
        addr_in = 32'h10; data_in = 32'h0;
        marLoad = 1'b1; mdrLoad = 1'b1;
        memEnable = 1'b1; RW = 1'b1; size = 2'b00;
        @(posedge clk); #1;
        addr_in = 32'h3FC; data_in = 32'h55;
        n = 1;
        while (!MOC && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("hold_latency", n, WC + 2);
        chk("hold_mar", mar_out, 32'h10);
        chk("hold_mdr", mdr_out, 32'hDEADBE01);
        marLoad = 1'b0; mdrLoad = 1'b0;
        seen = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen & MOC & busy;
        end
        chk("hold_moc", {31'h0, seen}, 1);
        memEnable = 1'b0;
        @(posedge clk); #1;
        chk("hold_release", {31'h0, MOC}, 0);

        // abort in WAIT leaves RAM and MDR alone
        access(1'b0, 2'b00, 32'h20, 32'h01020304, res);
        @(negedge clk);
        addr_in = 32'h20; data_in = 32'hCAFEF00D;
        marLoad = 1'b1; mdrLoad = 1'b1;
        memEnable = 1'b1; RW = 1'b0; size = 2'b00;
        @(posedge clk); #1;
        marLoad = 1'b0; mdrLoad = 1'b0;
        chk("abort_busy_wait", {31'h0, busy}, 1);
        memEnable = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle", {31'h0, busy}, 0);
        seen = MOC;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | MOC;
        end
        chk("abort_no_moc", {31'h0, seen}, 0);
        chk("abort_mdr", mdr_out, 32'hCAFEF00D);
        access(1'b1, 2'b00, 32'h20, 32'h0, res);
        chk("abort_ram", res, 32'h01020304);

        // reset while the write sits in XFER
        access(1'b0, 2'b00, 32'h24, 32'hA5A5A5A5, res);
        @(negedge clk);
        addr_in = 32'h24; data_in = 32'h12345678;
        marLoad = 1'b1; mdrLoad = 1'b1;
        memEnable = 1'b1; RW = 1'b0; size = 2'b00;
        repeat (WC + 1) begin
            @(posedge clk); #1;
            marLoad = 1'b0; mdrLoad = 1'b0;
        end
        chk("xfer_mdr", mdr_out, 32'h12345678);
        #1 reset = 1'b0;
        #1;
        chk("rstx_moc", {31'h0, MOC}, 0);
        chk("rstx_mar", mar_out, 0);
        chk("rstx_mdr", mdr_out, 0);
        chk("rstx_busy", {31'h0, busy}, 0);
        @(negedge clk);
        memEnable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        access(1'b1, 2'b00, 32'h24, 32'h0, res);
        chk("rstx_ram", res, 32'hA5A5A5A5);

        // misaligned word write
        access(1'b0, 2'b00, 32'h13, 32'h99887766, res);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_flag", {31'h0, align_err}, 1);
        access(1'b1, 2'b00, 32'h10, 32'h0, res);
        chk("mis_ram", res, 32'hDEADBE01);
        chk("mis_clear", {31'h0, align_err}, 0);
`else
        chk("mis_flag", {31'h0, align_err}, 0);
        access(1'b1, 2'b00, 32'h10, 32'h0, res);
        chk("mis_ram", res, 32'h99887766);
`endif

        // random traffic against the model in 0x100..0x17F
        for (int i = 0; i < 32; i++) begin
            a = 32'h100 + 32'(4 * i);
            d = $urandom;
            access(1'b0, 2'b00, a, d, res);
            m_write(2'b00, a, d);
        end
        for (int i = 0; i < 60; i++) begin
            rw = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 127));
            if (sz == 2'b00 || sz == 2'b11) a = a & ~32'h3;
            a  = a + 32'h100
                 + (32'($urandom_range(0, 7)) << 10);
            d  = $urandom;
            if (rw) begin
                e = m_read(sz, a);
            end else begin
                e = d;
                m_write(sz, a, d);
            end
            access(rw, sz, a, d, res);
            chk($sformatf("rand%0d", i), res, e);
        end
        for (int i = 0; i < 32; i++) begin
            a = 32'h100 + 32'(4 * i);
            access(1'b1, 2'b00, a, 32'h0, res);
            chk($sformatf("final%0d", i), res,
                m_read(2'b00, a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
